spi_cmd_sequencer: RTL and testbench
====================================

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- CMD_W, 24: command/response width.
- N_INIT, 4: number of init commands.
- N_READ, 7: number of read commands per frame.
- IDX_W, 3: width of data_index; 2**IDX_W >= N_READ.
- STARTUP_CYC, 40: power-up delay.
- RST_WAIT_CYC, 50000: delay after init command 0.
- POLL_CYC, 500000: delay between frames in continuous mode.
- TIMEOUT_CYC, 1024: maximum wait for cmd_done.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- continuous, in, 1: 1 = loop frames, 0 = single-shot.
- trigger, in, 1: starts one frame from IDLE.
- clear_err, in, 1: leaves ERROR.
- init_cmds, in, N_INIT*CMD_W: init command k at bits [k*CMD_W +: CMD_W].
- read_cmds, in, N_READ*CMD_W: read command k at the same slicing.
- start_command, out, 1: request to SPI controller.
- command, out, CMD_W: command word presented to SPI controller.
- cmd_done, in, 1: one-cycle completion pulse from SPI controller.
- rx_data, in, CMD_W: response word, valid with cmd_done.
- data_out, out, 8: captured read byte.
- data_valid, out, 1: one-cycle strobe for data_out.
- data_index, out, IDX_W: read index of data_out.
- frame_done, out, 1: one-cycle strobe at the end of a frame.
- frame_count, out, 16: completed frames.
- busy, out, 1: high in every state except IDLE and ERROR.
- timeout_err, out, 1: sticky timeout flag.

Function
REQ-003 States SHALL be STARTUP, INIT_CMD, INIT_WAIT, READ_CMD, FRAME_END, POLL_WAIT, IDLE, ERROR. A single cycle counter SHALL clear on every state change.

REQ-004 STARTUP SHALL go to INIT_CMD with index 0 when the counter reaches STARTUP_CYC-1.

REQ-005 INIT_CMD SHALL drive start_command=1 and command=init_cmds[idx] until cmd_done. On cmd_done:
- idx 0 goes to INIT_WAIT.
- idx < N_INIT-1 increments idx and stays in INIT_CMD.
- the last idx goes to READ_CMD with index 0.

REQ-006 INIT_WAIT SHALL drive start_command=0 and go to INIT_CMD idx 1 after RST_WAIT_CYC cycles. If N_INIT=1, it goes to READ_CMD instead.

REQ-007 READ_CMD SHALL drive start_command=1 and command=read_cmds[idx]. On cmd_done it SHALL register data_out=rx_data[7:0], data_index=idx and data_valid=1 in the next cycle, then:
- advance idx, or
- go to FRAME_END after idx N_READ-1.

REQ-008 start_command SHALL drop to 0 for exactly one cycle between consecutive commands, i.e. in the cycle following cmd_done.

REQ-009 FRAME_END SHALL last one cycle:
- frame_done=1.
- frame_count increments, wrapping 16'hFFFF to 0.
- continuous sampled here: 1 goes to POLL_WAIT, 0 goes to IDLE.

REQ-010 POLL_WAIT SHALL go to READ_CMD idx 0 after POLL_CYC cycles. Init commands are never re-issued except after reset or clear_err.

REQ-011 IDLE SHALL go to READ_CMD idx 0 on trigger=1. trigger in any other state SHALL be ignored.

REQ-012 In INIT_CMD or READ_CMD, if the counter reaches TIMEOUT_CYC-1 without cmd_done, the block SHALL:
- go to ERROR,
- set timeout_err=1,
- set start_command=0.

REQ-013 If cmd_done and the timeout occur in the same cycle, cmd_done SHALL win.

REQ-014 ERROR SHALL hold until clear_err=1, then go to STARTUP (full re-init). timeout_err SHALL clear on that same transition.

REQ-015 In states that do not issue a command, command SHALL equal 0. A cmd_done arriving in those states SHALL be ignored.

REQ-016 data_valid and frame_done SHALL never be high for more than one consecutive cycle.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL:
- enter STARTUP with counter, idx, frame_count, data_out and data_index at 0,
- drive start_command, data_valid, frame_done and timeout_err to 0,
- drive busy to 1.

REQ-018 Reset asserted mid-command SHALL drop start_command in the following cycle, with no data_valid emitted.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Defaults, SPI model answering cmd_done 30 cycles after start: init_cmds[0] issued at cycle 40; init_cmds[1] issued 50000 cycles after its done; 7 data_valid pulses with data_index 0..6, then frame_done with frame_count=1.
- continuous=0, frame finished: block in IDLE with busy=0; trigger pulse gives 7 reads, no init commands, frame_count=2.
- continuous=1: second frame's first start_command exactly POLL_CYC cycles after frame_done.
- cmd_done never returned for read 3: ERROR after 1024 cycles, timeout_err=1, start_command=0; clear_err re-runs STARTUP and clears timeout_err.
- cmd_done on the same cycle the counter hits TIMEOUT_CYC-1: normal advance, timeout_err stays 0.
- Reset during READ_CMD idx 2 and frame_count preset at 16'hFFFF: all outputs at reset values; separately, a wrap test shows 16'hFFFF going to 0.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: power-up delay, one-shot init command list, then
// single-shot or periodic frames of read commands whose low bytes are captured.
module spi_cmd_sequencer #(
   parameter int CMD_W        = 24,
   parameter int N_INIT       = 4,
   parameter int N_READ       = 7,
   parameter int IDX_W        = 3,
   parameter int STARTUP_CYC  = 40,
   parameter int RST_WAIT_CYC = 50000,
   parameter int POLL_CYC     = 500000,
   parameter int TIMEOUT_CYC  = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    continuous,
   input  logic                    trigger,
   input  logic                    clear_err,
   input  logic [N_INIT*CMD_W-1:0] init_cmds,
   input  logic [N_READ*CMD_W-1:0] read_cmds,
   output logic                    start_command,
   output logic [CMD_W-1:0]        command,
   input  logic                    cmd_done,
   input  logic [CMD_W-1:0]        rx_data,
   output logic [7:0]              data_out,
   output logic                    data_valid,
   output logic [IDX_W-1:0]        data_index,
   output logic                    frame_done,
   output logic [15:0]             frame_count,
   output logic                    busy,
   output logic                    timeout_err
);
   // state        | meaning
   // ST_STARTUP   | power-up delay
   // ST_INIT_CMD  | issue init_cmds[idx], wait for cmd_done
   // ST_INIT_WAIT | settle time after init command 0
   // ST_READ_CMD  | issue read_cmds[idx], capture response byte
   // ST_FRAME_END | one-cycle frame strobe, choose poll or idle
   // ST_POLL_WAIT | inter-frame delay in continuous mode
   // ST_IDLE      | wait for trigger
   // ST_ERROR     | command timed out, wait for clear_err
   typedef enum logic [2:0] {
      ST_STARTUP, ST_INIT_CMD, ST_INIT_WAIT, ST_READ_CMD,
      ST_FRAME_END, ST_POLL_WAIT, ST_IDLE, ST_ERROR
   } state_t;

   localparam int MAX_A   = (STARTUP_CYC > RST_WAIT_CYC) ? STARTUP_CYC : RST_WAIT_CYC;
   localparam int MAX_B   = (POLL_CYC > TIMEOUT_CYC) ? POLL_CYC : TIMEOUT_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int MAX_N   = (N_INIT > N_READ) ? N_INIT : N_READ;
   localparam int IW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   // Wait delays count from the triggering done/frame_done cycle itself.
   localparam logic [CNT_W-1:0] STARTUP_LAST  = CNT_W'(STARTUP_CYC - 1);
   localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 2);
   localparam logic [CNT_W-1:0] POLL_LAST     = CNT_W'(POLL_CYC - 2);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [IW-1:0]    INIT_LAST     = IW'(N_INIT - 1);
   localparam logic [IW-1:0]    READ_LAST     = IW'(N_READ - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             gap_q, gap_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic [7:0]       data_out_q, data_out_d;
   logic [IDX_W-1:0] data_index_q, data_index_d;
   logic             data_valid_q, data_valid_d;
   logic             timeout_err_q, timeout_err_d;

   logic cmd_state, done_acc, timed_out, unused_rx_hi;

   assign cmd_state    = (state_q == ST_INIT_CMD) || (state_q == ST_READ_CMD);
   assign done_acc     = cmd_state && !gap_q && cmd_done;
   assign timed_out    = cmd_state && !done_acc && (cnt_q == TIMEOUT_LAST);
   assign unused_rx_hi = ^rx_data[CMD_W-1:8];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_STARTUP;
         cnt_q         <= '0;
         idx_q         <= '0;
         gap_q         <= 1'b0;
         frame_count_q <= '0;
         data_out_q    <= '0;
         data_index_q  <= '0;
         data_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         gap_q         <= gap_d;
         frame_count_q <= frame_count_d;
         data_out_q    <= data_out_d;
         data_index_q  <= data_index_d;
         data_valid_q  <= data_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = 1'b0;
      unique case (state_q)
         ST_STARTUP:
            if (cnt_q == STARTUP_LAST) begin
               state_d = ST_INIT_CMD;
               idx_d   = '0;
            end
         ST_INIT_CMD:
            if (done_acc) begin
               if (idx_q == '0) begin
                  state_d = ST_INIT_WAIT;
               end else if (idx_q < INIT_LAST) begin
                  idx_d = idx_q + 1'b1;
                  gap_d = 1'b1;
               end else begin
                  state_d = ST_READ_CMD;
                  idx_d   = '0;
                  gap_d   = 1'b1;
               end
            end else if (timed_out) begin
               state_d = ST_ERROR;
            end
         ST_INIT_WAIT:
            if (cnt_q == RST_WAIT_LAST) begin
               state_d = (N_INIT == 1) ? ST_READ_CMD : ST_INIT_CMD;
               idx_d   = (N_INIT == 1) ? '0 : IW'(1);
            end
         ST_READ_CMD:
            if (done_acc) begin
               if (idx_q == READ_LAST) begin
                  state_d = ST_FRAME_END;
               end else begin
                  idx_d = idx_q + 1'b1;
                  gap_d = 1'b1;
               end
            end else if (timed_out) begin
               state_d = ST_ERROR;
            end
         ST_FRAME_END:
            state_d = continuous ? ST_POLL_WAIT : ST_IDLE;
         ST_POLL_WAIT:
            if (cnt_q == POLL_LAST) begin
               state_d = ST_READ_CMD;
               idx_d   = '0;
            end
         ST_IDLE:
            if (trigger) begin
               state_d = ST_READ_CMD;
               idx_d   = '0;
            end
         ST_ERROR:
            if (clear_err) state_d = ST_STARTUP;
         default: state_d = ST_STARTUP;
      endcase
   end

   // Counter also restarts per command and holds through the one-cycle gap,
   // so every command gets the full TIMEOUT_CYC window of start_command.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if ((state_d != state_q) || done_acc || gap_q) cnt_d = '0;
      frame_count_d = frame_count_q;
      if ((state_q == ST_READ_CMD) && (state_d == ST_FRAME_END))
         frame_count_d = frame_count_q + 16'd1;
      data_valid_d = (state_q == ST_READ_CMD) && done_acc;
      data_out_d   = data_out_q;
      data_index_d = data_index_q;
      if (data_valid_d) begin
         data_out_d   = rx_data[7:0];
         data_index_d = IDX_W'(idx_q);
      end
      timeout_err_d = timeout_err_q;
      if (timed_out)
         timeout_err_d = 1'b1;
      else if ((state_q == ST_ERROR) && clear_err)
         timeout_err_d = 1'b0;
   end

   always_comb begin
      start_command = cmd_state && !gap_q;
      command       = '0;
      if (state_q == ST_INIT_CMD) begin
         for (int k = 0; k < N_INIT; k++)
            if (idx_q == IW'(k)) command = init_cmds[k*CMD_W +: CMD_W];
      end else if (state_q == ST_READ_CMD) begin
         for (int k = 0; k < N_READ; k++)
            if (idx_q == IW'(k)) command = read_cmds[k*CMD_W +: CMD_W];
      end
      busy       = (state_q != ST_IDLE) && (state_q != ST_ERROR);
      frame_done = (state_q == ST_FRAME_END);
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign data_index  = data_index_q;
   assign frame_count = frame_count_q;
   assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: SPI responder model plus scoreboard queues for
// issued commands, captured bytes and frame counts.
module tb_spi_cmd_sequencer;
   localparam int CMD_W        = 24;
   localparam int N_INIT       = 4;
   localparam int N_READ       = 7;
   localparam int IDX_W        = 3;
   localparam int STARTUP_CYC  = 40;
   localparam int RST_WAIT_CYC = 300;
   localparam int POLL_CYC     = 400;
   localparam int TIMEOUT_CYC  = 1024;

   logic clk = 1'b0;
   logic reset = 1'b1, continuous = 1'b0, trigger = 1'b0, clear_err = 1'b0;
   logic [N_INIT*CMD_W-1:0] init_cmds;
   logic [N_READ*CMD_W-1:0] read_cmds;
   logic start_command;
   logic [CMD_W-1:0] command;
   logic spi_done = 1'b0, spur_done = 1'b0, cmd_done;
   logic [CMD_W-1:0] rx_data = '0;
   logic [7:0] data_out;
   logic data_valid, frame_done, busy, timeout_err;
   logic [IDX_W-1:0] data_index;
   logic [15:0] frame_count;

   assign cmd_done = spi_done | spur_done;

   spi_cmd_sequencer #(
      .CMD_W(CMD_W), .N_INIT(N_INIT), .N_READ(N_READ), .IDX_W(IDX_W),
      .STARTUP_CYC(STARTUP_CYC), .RST_WAIT_CYC(RST_WAIT_CYC),
      .POLL_CYC(POLL_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .continuous(continuous), .trigger(trigger),
      .clear_err(clear_err), .init_cmds(init_cmds), .read_cmds(read_cmds),
      .start_command(start_command), .command(command), .cmd_done(cmd_done),
      .rx_data(rx_data), .data_out(data_out), .data_valid(data_valid),
      .data_index(data_index), .frame_done(frame_done), .frame_count(frame_count),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [CMD_W-1:0] init_arr [N_INIT];
   logic [CMD_W-1:0] read_arr [N_READ];
   logic [CMD_W-1:0] exp_cmd_q [$];
   logic [15:0]      exp_data_q [$];
   logic [15:0]      exp_fc_q [$];
   int start_log [$];
   int done_log [$];
   int fd_cnt = 0;
   int last_fd_cyc = 0;
   logic [15:0] model_fc = 16'd0;
   int checks = 0, failures = 0;
   bit spi_rand = 1'b0;
   int slow_idx = -1, drop_idx = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int read_index(input logic [CMD_W-1:0] c);
      for (int k = 0; k < N_READ; k++) if (read_arr[k] == c) return k;
      return -1;
   endfunction

   // SPI controller model: answers a started command after a latency
   initial begin : spi_model
      int remain, ridx;
      bit active, hold;
      active = 1'b0; hold = 1'b0; remain = 0; ridx = -1;
      forever begin
         @(negedge clk);
         if (spi_done) begin
            spi_done = 1'b0;
            chk("start_gap_after_done", start_command, 0);
         end else if (active) begin
            if (!start_command) begin
               active = 1'b0;
            end else if (!hold) begin
               remain--;
               if (remain == 0) begin
                  rx_data  = CMD_W'($urandom);
                  spi_done = 1'b1;
                  active   = 1'b0;
                  done_log.push_back(cyc);
                  if (ridx >= 0) exp_data_q.push_back({8'(ridx), rx_data[7:0]});
               end
            end
         end else if (start_command && !reset) begin
            active = 1'b1;
            ridx   = read_index(command);
            remain = spi_rand ? int'($urandom_range(1, 40)) : 30;
            if (ridx >= 0 && ridx == slow_idx) remain = TIMEOUT_CYC - 1;
            hold   = (ridx >= 0 && ridx == drop_idx);
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an output
   initial begin : monitor
      logic prev_start, prev_dv, prev_fd;
      logic [15:0] e;
      prev_start = 1'b0; prev_dv = 1'b0; prev_fd = 1'b0;
      forever begin
         @(negedge clk);
         if (start_command && !prev_start) begin
            start_log.push_back(cyc);
            if (exp_cmd_q.size() == 0) chk("unexpected_command", command, 0);
            else chk("command_word", command, exp_cmd_q.pop_front());
         end
         if (data_valid) begin
            if (prev_dv) chk("data_valid_single", 1, 0);
            if (exp_data_q.size() == 0) begin
               chk("unexpected_data_valid", {data_index, data_out}, 0);
            end else begin
               e = exp_data_q.pop_front();
               chk("data_index", data_index, e[15:8]);
               chk("data_out", data_out, e[7:0]);
            end
         end
         if (frame_done) begin
            if (prev_fd) chk("frame_done_single", 1, 0);
            fd_cnt++;
            last_fd_cyc = cyc;
            if (exp_fc_q.size() == 0) chk("unexpected_frame_done", frame_count, 0);
            else chk("frame_count", frame_count, exp_fc_q.pop_front());
         end
         if (!busy && !reset) begin
            chk("quiet_command", command, 0);
            chk("quiet_start", start_command, 0);
         end
         prev_start = start_command; prev_dv = data_valid; prev_fd = frame_done;
      end
   end

   task automatic push_reads(input int n);
      for (int k = 0; k < n; k++) exp_cmd_q.push_back(read_arr[k]);
   endtask

   task automatic push_frame(input bit with_init);
      if (with_init) for (int k = 0; k < N_INIT; k++) exp_cmd_q.push_back(init_arr[k]);
      push_reads(N_READ);
      model_fc = model_fc + 16'd1;
      exp_fc_q.push_back(model_fc);
   endtask

   task automatic do_reset(output int r);
      @(negedge clk);
      reset = 1'b1;
      r = cyc;
      exp_cmd_q.delete(); exp_data_q.delete(); exp_fc_q.delete();
      start_log.delete(); done_log.delete();
      model_fc = 16'd0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_vals();
      chk("rst_start_command", start_command, 0);
      chk("rst_command", command, 0);
      chk("rst_busy", busy, 1);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_data_index", data_index, 0);
   endtask

   task automatic pulse(input int which);
      @(negedge clk);
      if (which == 0) trigger = 1'b1; else if (which == 1) clear_err = 1'b1; else spur_done = 1'b1;
      @(negedge clk);
      trigger = 1'b0; clear_err = 1'b0; spur_done = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int budget);
      int n = 0;
      while (fd_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (fd_cnt < target) chk("frame_done_wait_expired", fd_cnt, target);
   endtask

   task automatic wait_start(input int target, input int budget);
      int n = 0;
      while (start_log.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (start_log.size() < target) chk("start_wait_expired", start_log.size(), target);
   endtask

   task automatic check_init_timing(input int base, input string tag);
      if (start_log.size() < 2 || done_log.size() < 1) begin
         chk({tag, "_init_log"}, start_log.size(), 2);
      end else begin
         chk({tag, "_init0_cycle"}, start_log[0] - base, STARTUP_CYC);
         chk({tag, "_init1_after_done"}, start_log[1] - done_log[0], RST_WAIT_CYC);
      end
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_cmd_q_empty"}, exp_cmd_q.size(), 0);
      chk({tag, "_data_q_empty"}, exp_data_q.size(), 0);
      chk({tag, "_fc_q_empty"}, exp_fc_q.size(), 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish required finish by cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin : main
      int r, c, fd3, e;
      for (int k = 0; k < N_INIT; k++) begin
         init_arr[k] = {8'(8'hA0 + k), 16'($urandom)};
         init_cmds[k*CMD_W +: CMD_W] = init_arr[k];
      end
      for (int k = 0; k < N_READ; k++) begin
         read_arr[k] = {8'(8'hB0 + k), 16'($urandom)};
         read_cmds[k*CMD_W +: CMD_W] = read_arr[k];
      end

      // power-up frame with fixed 30-cycle SPI latency
      do_reset(r);
      check_reset_vals();
      push_frame(1'b1);
      wait_fd(1, 4000);
      check_init_timing(r + 1, "s1");
      repeat (3) @(negedge clk);
      chk("s1_idle_busy", busy, 0);
      check_drained("s1");

      // triggered single shot, second trigger mid-frame ignored
      spi_rand = 1'b1;
      push_frame(1'b0);
      start_log.delete();
      pulse(0);
      wait_start(2, 200);
      pulse(0);
      wait_fd(2, 2000);
      repeat (3) @(negedge clk);
      pulse(2);
      repeat (3) @(negedge clk);
      chk("s2_idle_busy", busy, 0);
      check_drained("s2");

      // continuous mode: next frame starts POLL_CYC after frame_done
      continuous = 1'b1;
      push_frame(1'b0);
      pulse(0);
      wait_fd(3, 2000);
      fd3 = last_fd_cyc;
      start_log.delete();
      push_frame(1'b0);
      wait_start(1, POLL_CYC + 20);
      if (start_log.size() > 0) chk("s3_poll_gap", start_log[0] - fd3, POLL_CYC);
      continuous = 1'b0;
      wait_fd(4, 2000);
      repeat (3) @(negedge clk);
      chk("s3_idle_busy", busy, 0);
      check_drained("s3");

      // cmd_done exactly on the last allowed counter value
      slow_idx = 4;
      push_frame(1'b0);
      pulse(0);
      wait_fd(5, 3000);
      slow_idx = -1;
      chk("s4_no_timeout", timeout_err, 0);
      check_drained("s4");

      // read 3 never answered
      drop_idx = 3;
      push_reads(4);
      start_log.delete();
      pulse(0);
      e = -1;
      for (int n = 0; n < 3000 && e < 0; n++) begin
         @(negedge clk);
         if (timeout_err) e = cyc;
      end
      if (e < 0 || start_log.size() < 4) begin
         chk("s5_timeout_seen", timeout_err, 1);
      end else begin
         chk("s5_timeout_latency", e - start_log[3], TIMEOUT_CYC);
         chk("s5_err_start", start_command, 0);
         chk("s5_err_busy", busy, 0);
      end
      drop_idx = -1;
      pulse(2);
      repeat (10) @(negedge clk);
      chk("s5_err_sticky", timeout_err, 1);
      chk("s5_err_still_idle", busy, 0);
      check_drained("s5_err");
      @(negedge clk);
      clear_err = 1'b1;
      c = cyc;
      start_log.delete(); done_log.delete();
      push_frame(1'b1);
      @(negedge clk);
      clear_err = 1'b0;
      chk("s5_clear_timeout_err", timeout_err, 0);
      chk("s5_clear_busy", busy, 1);
      wait_fd(6, 4000);
      check_init_timing(c + 1, "s5");
      check_drained("s5");

      // frame_count wrap 16'hFFFF -> 0
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      model_fc = 16'hFFFF;
      push_frame(1'b0);
      pulse(0);
      wait_fd(7, 2000);
      repeat (2) @(negedge clk);
      chk("s6_wrapped_count", frame_count, 0);
      check_drained("s6");

      // reset while read 2 is outstanding, count preset to 16'hFFFF
      spi_rand = 1'b0;
      @(negedge clk);
      force dut.frame_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_q;
      push_frame(1'b0);
      start_log.delete();
      pulse(0);
      wait_start(3, 200);
      do_reset(r);
      check_reset_vals();
      push_frame(1'b1);
      wait_fd(8, 4000);
      check_init_timing(r + 1, "s7");
      repeat (3) @(negedge clk);
      check_drained("s7");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
